// File: rtl/mem_arbiter_if.sv
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Fetch/data requester buses and single-port RAM bus of the
//                memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Requester / RAM side
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port (fetch/data) arbiter onto one single-port RAM,
//                one transaction at a time. Define ARB_RR_EN for round-robin
//                arbitration; otherwise the data port has fixed priority.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int AW       = 6,
    parameter int DW       = 32,
    parameter int WAIT_CYC = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    localparam logic [3:0] c_WAIT_LAST = 4'(WAIT_CYC - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_wait_cnt;
    logic          r_grant_d;
    logic          r_store;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_i_ack;
    logic          r_d_ack;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          w_prio_d;
    logic          w_grant_d;
    logic          w_any_req;
    logic          w_capture;

`ifdef ARB_RR_EN
    logic r_prio_d;

    // Priority flips to the port that was not just served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio_d <= 1'b1;
        end else if (r_state == ST_ACK) begin
            r_prio_d <= ~r_grant_d;
        end
    end

    assign w_prio_d = r_prio_d;
`else
    assign w_prio_d = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_any_req   = bus.i_req | bus.d_req;
        w_grant_d   = bus.d_req & (~bus.i_req | w_prio_d);
        w_capture   = (r_state == ST_WAIT) && (r_wait_cnt == 4'd0);
        case (r_state)
            ST_IDLE:   if (w_any_req) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_WAIT;
            ST_WAIT:   if (r_wait_cnt == 4'd0) w_state_nxt = ST_ACK;
            ST_ACK:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobes and acks are decoded from the next state so they leave flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= 4'd0;
            r_grant_d   <= 1'b0;
            r_store     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mem_en <= (w_state_nxt == ST_ACCESS);
            r_mem_we <= (w_state_nxt == ST_ACCESS) && w_grant_d && bus.d_we;
            r_i_ack  <= (w_state_nxt == ST_ACK) && !r_grant_d;
            r_d_ack  <= (w_state_nxt == ST_ACK) && r_grant_d;

            if (r_state == ST_IDLE && w_any_req) begin
                r_grant_d   <= w_grant_d;
                r_store     <= w_grant_d & bus.d_we;
                r_mem_addr  <= w_grant_d ? bus.d_addr : bus.i_addr;
                r_mem_wdata <= w_grant_d ? bus.d_wdata : '0;
            end

            if (r_state == ST_ACCESS) begin
                r_wait_cnt <= c_WAIT_LAST;
            end else if (r_state == ST_WAIT && r_wait_cnt != 4'd0) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end

            if (w_capture) begin
                if (!r_grant_d) begin
                    r_i_rdata <= bus.mem_rdata;
                end else if (!r_store) begin
                    r_d_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.i_ack     = r_i_ack;
    assign bus.d_ack     = r_d_ack;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed bench for mem_arbiter (WAIT_CYC=1 and WAIT_CYC=3
//                instances, exact-latency RAM models).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam logic [31:0] c_BAD = 32'hBAD0_BAD0;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    logic [31:0] ram [0:63];
    logic [31:0] r_p1;
    logic [31:0] r_p3 [0:2];

    mem_arbiter_if #(.AW(6), .DW(32)) b1 ();
    mem_arbiter_if #(.AW(6), .DW(32)) b3 ();

    mem_arbiter #(.AW(6), .DW(32), .WAIT_CYC(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    mem_arbiter #(.AW(6), .DW(32), .WAIT_CYC(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data appears exactly WAIT_CYC cycles after mem_en, garbage otherwise
    always @(posedge clk) begin
        if (rst) begin
            ram[5] <= 32'h0050_0093;
            ram[2] <= 32'h1234_5678;
        end else if (b1.mem_en && b1.mem_we) begin
            ram[b1.mem_addr] <= b1.mem_wdata;
        end
        r_p1    <= b1.mem_en ? ram[b1.mem_addr] : c_BAD;
        r_p3[0] <= b3.mem_en ? ram[b3.mem_addr] : c_BAD;
        r_p3[1] <= r_p3[0];
        r_p3[2] <= r_p3[1];
    end

    assign b1.mem_rdata = r_p1;
    assign b3.mem_rdata = r_p3[2];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_total++;
        if ({b1.i_ack, b1.d_ack, b1.mem_en, b1.mem_we, b1.busy, b1.i_rdata,
             b1.d_rdata, b1.mem_addr, b1.mem_wdata} !== '0) begin
            $display("FAIL reset_dut1 got i_ack=%b d_ack=%b en=%b we=%b busy=%b ird=%h drd=%h addr=%h wd=%h exp all 0",
                     b1.i_ack, b1.d_ack, b1.mem_en, b1.mem_we, b1.busy,
                     b1.i_rdata, b1.d_rdata, b1.mem_addr, b1.mem_wdata);
        end else n_pass++;
        n_total++;
        if ({b3.i_ack, b3.d_ack, b3.mem_en, b3.mem_we, b3.busy, b3.i_rdata,
             b3.d_rdata, b3.mem_addr, b3.mem_wdata} !== '0) begin
            $display("FAIL reset_dut3 got en=%b busy=%b ird=%h exp all 0",
                     b3.mem_en, b3.busy, b3.i_rdata);
        end else n_pass++;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        n_total++;
        if ({b1.busy, b1.mem_en, b1.i_ack, b1.d_ack} !== 4'b0000) begin
            $display("FAIL idle_after_reset got busy=%b en=%b ia=%b da=%b exp 0",
                     b1.busy, b1.mem_en, b1.i_ack, b1.d_ack);
        end else n_pass++;
        next_cycle();
    endtask

    task automatic test_fetch();
        logic [3:0] obs;
        logic [3:0] exp;
        b1.i_req  = 1'b1;
        b1.i_addr = 6'd5;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) b1.i_req = 1'b0;
            @(negedge clk);
            exp = {c == 1, (c >= 1 && c <= 3), c == 3, 1'b0};
            obs = {b1.mem_en, b1.busy, b1.i_ack, b1.d_ack};
            n_total++;
            if (obs !== exp) $display("FAIL fetch_ctl c=%0d got {en,busy,ia,da}=%b exp %b", c, obs, exp);
            else n_pass++;
            if (c == 1) begin
                n_total++;
                if ({b1.mem_we, b1.mem_addr} !== {1'b0, 6'd5})
                    $display("FAIL fetch_addr got we=%b addr=%h exp we=0 addr=05", b1.mem_we, b1.mem_addr);
                else n_pass++;
            end
            if (c == 3) begin
                n_total++;
                if (b1.i_rdata !== 32'h0050_0093)
                    $display("FAIL fetch_data got %h exp 00500093", b1.i_rdata);
                else n_pass++;
            end
            next_cycle();
        end
    endtask

    task automatic test_store_load();
        logic [4:0] obs;
        logic [4:0] exp;
        b1.d_req   = 1'b1;
        b1.d_we    = 1'b1;
        b1.d_addr  = 6'h10;
        b1.d_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) b1.d_req = 1'b0;
            @(negedge clk);
            exp = {c == 1, c == 1, (c >= 1 && c <= 3), 1'b0, c == 3};
            obs = {b1.mem_en, b1.mem_we, b1.busy, b1.i_ack, b1.d_ack};
            n_total++;
            if (obs !== exp) $display("FAIL store_ctl c=%0d got {en,we,busy,ia,da}=%b exp %b", c, obs, exp);
            else n_pass++;
            if (c == 1) begin
                n_total++;
                if ({b1.mem_addr, b1.mem_wdata} !== {6'h10, 32'hDEAD_BEEF})
                    $display("FAIL store_bus got addr=%h wd=%h exp 10 deadbeef", b1.mem_addr, b1.mem_wdata);
                else n_pass++;
            end
            if (c == 3) begin
                n_total++;
                if (b1.d_rdata !== 32'h0)
                    $display("FAIL store_rdata_hold got %h exp 00000000", b1.d_rdata);
                else n_pass++;
            end
            next_cycle();
        end
        b1.d_req = 1'b1;
        b1.d_we  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) b1.d_req = 1'b0;
            @(negedge clk);
            exp = {c == 1, 1'b0, (c >= 1 && c <= 3), 1'b0, c == 3};
            obs = {b1.mem_en, b1.mem_we, b1.busy, b1.i_ack, b1.d_ack};
            n_total++;
            if (obs !== exp) $display("FAIL load_ctl c=%0d got {en,we,busy,ia,da}=%b exp %b", c, obs, exp);
            else n_pass++;
            if (c == 3) begin
                n_total++;
                if (b1.d_rdata !== 32'hDEAD_BEEF)
                    $display("FAIL load_data got %h exp deadbeef", b1.d_rdata);
                else n_pass++;
            end
            if (c == 5) begin
                n_total++;
                if (b1.i_rdata !== 32'h0050_0093)
                    $display("FAIL irdata_hold got %h exp 00500093", b1.i_rdata);
                else n_pass++;
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] obs;
        logic [1:0] exp;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        b1.d_req  = 1'b1;
        b1.d_we   = 1'b0;
        b1.d_addr = 6'h10;
        b1.i_req  = 1'b1;
        b1.i_addr = 6'd5;
        for (int c = 0; c < 17; c++) begin
            if (c == 12) b1.d_req = 1'b0;
            if (c == 16) b1.i_req = 1'b0;
            @(negedge clk);
`ifdef ARB_RR_EN
            exp = {(c == 7 || c == 15), (c == 3 || c == 11)};
`else
            exp = {c == 15, (c == 3 || c == 7 || c == 11)};
`endif
            obs = {b1.i_ack, b1.d_ack};
            n_total++;
            if (obs !== exp) $display("FAIL b2b_acks c=%0d got {ia,da}=%b exp %b", c, obs, exp);
            else n_pass++;
            if (c == 11) begin
                n_total++;
                if (b1.d_rdata !== 32'hDEAD_BEEF)
                    $display("FAIL b2b_ddata got %h exp deadbeef", b1.d_rdata);
                else n_pass++;
            end
            if (c == 15) begin
                n_total++;
                if (b1.i_rdata !== 32'h0050_0093)
                    $display("FAIL b2b_idata got %h exp 00500093", b1.i_rdata);
                else n_pass++;
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] obs;
        logic [2:0] exp;
        b1.d_req  = 1'b1;
        b1.d_we   = 1'b0;
        b1.d_addr = 6'h10;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) begin
                #2;
                rst = 1'b1;
            end
            if (c == 3) rst = 1'b0;
            if (c == 7) b1.d_req = 1'b0;
            @(negedge clk);
            exp = {(c == 1 || c == 4), (c == 1 || (c >= 4 && c <= 6)), c == 6};
            obs = {b1.mem_en, b1.busy, b1.d_ack};
            n_total++;
            if (obs !== exp) $display("FAIL rstmid_ctl c=%0d got {en,busy,da}=%b exp %b", c, obs, exp);
            else n_pass++;
            if (c == 2) begin
                n_total++;
                if ({b1.i_ack, b1.mem_we, b1.i_rdata, b1.d_rdata, b1.mem_addr, b1.mem_wdata} !== '0)
                    $display("FAIL rstmid_outs got ird=%h drd=%h addr=%h wd=%h exp all 0",
                             b1.i_rdata, b1.d_rdata, b1.mem_addr, b1.mem_wdata);
                else n_pass++;
            end
            if (c == 6) begin
                n_total++;
                if (b1.d_rdata !== 32'hDEAD_BEEF)
                    $display("FAIL rstmid_data got %h exp deadbeef", b1.d_rdata);
                else n_pass++;
            end
            next_cycle();
        end
    endtask

    task automatic test_wait3();
        logic [2:0] obs;
        logic [2:0] exp;
        int         n_en;
        n_en      = 0;
        b3.i_req  = 1'b1;
        b3.i_addr = 6'd2;
        for (int c = 0; c < 9; c++) begin
            if (c == 6) b3.i_req = 1'b0;
            @(negedge clk);
            if (b3.mem_en) n_en++;
            exp = {c == 1, (c >= 1 && c <= 5), c == 5};
            obs = {b3.mem_en, b3.busy, b3.i_ack};
            n_total++;
            if (obs !== exp) $display("FAIL wait3_ctl c=%0d got {en,busy,ia}=%b exp %b", c, obs, exp);
            else n_pass++;
            if (c == 5) begin
                n_total++;
                if (b3.i_rdata !== 32'h1234_5678)
                    $display("FAIL wait3_data got %h exp 12345678", b3.i_rdata);
                else n_pass++;
            end
            next_cycle();
        end
        n_total++;
        if (n_en != 1) $display("FAIL wait3_en_count got %0d exp 1", n_en);
        else n_pass++;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst        = 1'b1;
        b1.i_req   = 1'b0;
        b1.i_addr  = '0;
        b1.d_req   = 1'b0;
        b1.d_we    = 1'b0;
        b1.d_addr  = '0;
        b1.d_wdata = '0;
        b3.i_req   = 1'b0;
        b3.i_addr  = '0;
        b3.d_req   = 1'b0;
        b3.d_we    = 1'b0;
        b3.d_addr  = '0;
        b3.d_wdata = '0;
        #1;
        test_reset();
        test_fetch();
        next_cycle();
        test_store_load();
        next_cycle();
        test_back_to_back();
        next_cycle();
        test_reset_mid();
        next_cycle();
        test_wait3();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
